// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing and the derived sync-window constants.
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 10;
  localparam logic DEF_SYNC_POL = 1'b0;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;
endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL counter for one raster axis; wrap is combinational so the
// next axis can chain on it in the same strobe.
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap
);
  logic [CW-1:0] r_cnt;

  assign wrap = en && (r_cnt == CW'(TOTAL - 1));
  assign cnt  = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_cnt <= '0;
    else if (en) r_cnt <= wrap ? '0 : r_cnt + CW'(1);
  end
endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: h/v counters plus registered syncs, active-video
// flag and line/frame pulses, all decoded from next counter values.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL,
  parameter int   CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_end,
  output logic          frame_start
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic [CW-1:0] w_hcnt, w_vcnt, w_x_nxt, w_y_nxt;
  logic          w_hwrap, w_vwrap, w_ven;
  logic          r_hs, r_vs, r_vo, r_le, r_fs;

  assign w_ven = pix_en & w_hwrap;

  vga_axis_counter #(.TOTAL(H_TOTAL), .CW(CW)) u_h (
    .clk(clk), .rst(rst), .en(pix_en), .cnt(w_hcnt), .wrap(w_hwrap)
  );
  vga_axis_counter #(.TOTAL(V_TOTAL), .CW(CW)) u_v (
    .clk(clk), .rst(rst), .en(w_ven), .cnt(w_vcnt), .wrap(w_vwrap)
  );

  // Values the counters will hold after this strobe; only meaningful when pix_en=1.
  assign w_x_nxt = w_hwrap ? '0 : w_hcnt + CW'(1);
  assign w_y_nxt = w_vwrap ? '0 : (w_hwrap ? w_vcnt + CW'(1) : w_vcnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs <= ~SYNC_POL;
      r_vs <= ~SYNC_POL;
      r_vo <= 1'b0;
      r_le <= 1'b0;
      r_fs <= 1'b0;
    end else begin
      r_le <= w_ven;
      r_fs <= w_vwrap;
      if (pix_en) begin
        r_hs <= (w_x_nxt >= CW'(HS_START) && w_x_nxt <= CW'(HS_END)) ? SYNC_POL : ~SYNC_POL;
        r_vs <= (w_y_nxt >= CW'(VS_START) && w_y_nxt <= CW'(VS_END)) ? SYNC_POL : ~SYNC_POL;
        r_vo <= (w_x_nxt < CW'(H_ACTIVE)) && (w_y_nxt < CW'(V_ACTIVE));
      end
    end
  end

  assign pix_x       = w_hcnt;
  assign pix_y       = w_vcnt;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign video_on    = r_vo;
  assign line_end    = r_le;
  assign frame_start = r_fs;
endmodule
